// File: rtl/usb_evlog_pkg.sv
// Shared types and constants for usb_event_logger: FSM states, ASCII codes, line lengths.
// Optional timestamp support is enabled by USB_EVLOG_TIMESTAMP_EN (see usb_event_logger).
package usb_evlog_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} evlog_state_t;

  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned LINE_LEN_BASE = 5;
  localparam int unsigned LINE_LEN_TS   = 10;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/usb_evlog_fifo.sv
// Synchronous show-ahead FIFO; a push is accepted when full if a pop happens in the same cycle.
module usb_evlog_fifo
  import usb_evlog_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/usb_event_logger.sv
// Captures USB event strobes per channel, queues {chan, ep} and streams ASCII lines to uart_tx.
// Define USB_EVLOG_TIMESTAMP_EN to append a 16-bit microsecond timestamp to every line.
module usb_event_logger
  import usb_evlog_pkg::*;
#(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned EP_W  = 4
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic [NCHAN-1:0] ev,
  input  logic [EP_W-1:0]  endpoint,
  output logic [7:0]       q,
  output logic             dv,
  input  logic             done,
  output logic             overflow,
  output logic [7:0]       lost_cnt,
  output logic             fifo_empty
);

`ifdef USB_EVLOG_TIMESTAMP_EN
  localparam int unsigned ENTRY_W  = 4 + EP_W + 16;
  localparam int unsigned LINE_LEN = LINE_LEN_TS;
`else
  localparam int unsigned ENTRY_W  = 4 + EP_W;
  localparam int unsigned LINE_LEN = LINE_LEN_BASE;
`endif

  logic [NCHAN-1:0]   r_pending;
  logic [EP_W-1:0]    r_ep [NCHAN];
  logic               w_found;
  logic [3:0]         w_sel;
  logic [EP_W-1:0]    w_sel_ep;
  logic [NCHAN-1:0]   w_clr;
  logic [NCHAN-1:0]   w_lost;
  logic [4:0]         w_lost_n;
  logic [8:0]         w_lost_sum;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [ENTRY_W-1:0] r_line;
  evlog_state_t       r_state;
  logic [3:0]         r_idx;
  logic [7:0]         r_q;
  logic               r_dv;
  logic               r_overflow;
  logic [7:0]         r_lost_cnt;

`ifdef USB_EVLOG_TIMESTAMP_EN
  logic [5:0]  r_presc;
  logic [15:0] r_usec;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_usec  <= '0;
    end else if (r_presc == 6'd47) begin
      r_presc <= '0;
      r_usec  <= r_usec + 16'd1;
    end else begin
      r_presc <= r_presc + 6'd1;
    end
  end

  assign w_wdata = {w_sel, w_sel_ep, r_usec};
`else
  assign w_wdata = {w_sel, w_sel_ep};
`endif

  function automatic logic [7:0] line_byte(input logic [ENTRY_W-1:0] e, input logic [3:0] i);
    logic [3:0] chan;
    logic [3:0] ep;
    chan = e[ENTRY_W-1 -: 4];
    ep   = e[ENTRY_W-5 -: 4];
    case (i)
      4'd0:    return ASCII_E;
      4'd1:    return hex_to_ascii(chan);
      4'd2:    return hex_to_ascii(ep);
`ifdef USB_EVLOG_TIMESTAMP_EN
      4'd3:    return ASCII_SP;
      4'd4:    return hex_to_ascii(e[15:12]);
      4'd5:    return hex_to_ascii(e[11:8]);
      4'd6:    return hex_to_ascii(e[7:4]);
      4'd7:    return hex_to_ascii(e[3:0]);
      4'd8:    return ASCII_CR;
`else
      4'd3:    return ASCII_CR;
`endif
      default: return ASCII_LF;
    endcase
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_sel    = '0;
    w_sel_ep = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (r_pending[i] && !w_found) begin
        w_found  = 1'b1;
        w_sel    = 4'(i);
        w_sel_ep = r_ep[i];
      end
    end
  end

  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_push = w_found && (!w_full || w_pop);

  // A strobe landing on the cycle its pending bit drains re-arms the channel rather than being lost.
  always_comb begin
    w_clr    = '0;
    w_lost   = '0;
    w_lost_n = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      w_clr[i]  = w_push && (w_sel == 4'(i));
      w_lost[i] = ev[i] && r_pending[i] && !w_clr[i];
      w_lost_n  = w_lost_n + 5'(w_lost[i]);
    end
    w_lost_sum = {1'b0, r_lost_cnt} + {4'b0, w_lost_n};
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_lost_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        if (ev[i] && (!r_pending[i] || w_clr[i])) begin
          r_pending[i] <= 1'b1;
          r_ep[i]      <= endpoint;
        end else if (w_clr[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
      if (|w_lost) begin
        r_overflow <= 1'b1;
        r_lost_cnt <= w_lost_sum[8] ? 8'hFF : w_lost_sum[7:0];
      end
    end
  end

  usb_evlog_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk48),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // q/dv are loaded on the transition into SEND, so dv is high exactly while in SEND.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_q     <= '0;
      r_dv    <= 1'b0;
      r_line  <= '0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        IDLE: if (!w_empty) begin
          r_line  <= w_rdata;
          r_idx   <= '0;
          r_q     <= line_byte(w_rdata, 4'd0);
          r_dv    <= 1'b1;
          r_state <= SEND;
        end
        SEND: r_state <= WAIT;
        WAIT: if (done) begin
          if (r_idx == 4'(LINE_LEN - 1)) begin
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_q     <= line_byte(r_line, r_idx + 4'd1);
            r_dv    <= 1'b1;
            r_state <= SEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q          = r_q;
  assign dv         = r_dv;
  assign overflow   = r_overflow;
  assign lost_cnt   = r_lost_cnt;
  assign fifo_empty = w_empty;

endmodule

// File: tb/tb_usb_event_logger.sv
// Directed self-checking bench for usb_event_logger (also covers USB_EVLOG_TIMESTAMP_EN when defined).
`timescale 1ns/1ps
module tb_usb_event_logger;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned EP_W  = 4;
`ifdef USB_EVLOG_TIMESTAMP_EN
  localparam int LL = 10;
`else
  localparam int LL = 5;
`endif

  logic             clk48 = 1'b0;
  logic             rst_n;
  logic [NCHAN-1:0] ev;
  logic [EP_W-1:0]  endpoint;
  logic [7:0]       q;
  logic             dv;
  logic             done;
  logic             overflow;
  logic [7:0]       lost_cnt;
  logic             fifo_empty;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_cnt  = 0;

  always #10 clk48 = ~clk48;
  always @(negedge clk48) if (dv === 1'b1) dv_cnt++;

  usb_event_logger #(
    .NCHAN (NCHAN),
    .DEPTH (DEPTH),
    .EP_W  (EP_W)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .ev         (ev),
    .endpoint   (endpoint),
    .q          (q),
    .dv         (dv),
    .done       (done),
    .overflow   (overflow),
    .lost_cnt   (lost_cnt),
    .fifo_empty (fifo_empty)
  );

  function automatic logic [7:0] hexd(input int unsigned v);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[v];
  endfunction

  function automatic logic [39:0] exp_line(input int unsigned ch, input int unsigned ep);
    return {8'h45, hexd(ch), hexd(ep), 8'h0D, 8'h0A};
  endfunction

  task automatic pulse_ev(input logic [NCHAN-1:0] v, input logic [EP_W-1:0] e);
    ev = v;
    endpoint = e;
    @(negedge clk48);
    ev = '0;
  endtask

  // Waits (bounded) for a dv pulse; optionally answers with done ~10 cycles later.
  task automatic recv_byte(input bit give_done, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int c = 0; c < 400; c++) begin
      if (dv === 1'b1) begin
        ok = 1'b1;
        b  = q;
        break;
      end
      @(negedge clk48);
    end
    if (ok && give_done) begin
      repeat (9) @(negedge clk48);
      done = 1'b1;
      @(negedge clk48);
      done = 1'b0;
    end else if (ok) begin
      @(negedge clk48);
    end
  endtask

  task automatic recv_line(input int first, output logic [39:0] hd, output logic [39:0] ts,
                           output bit ok);
    logic [7:0] b [LL];
    logic [7:0] t;
    bit         bok;
    for (int i = 0; i < LL; i++) b[i] = '0;
    b[0] = 8'h45;
    ok = 1'b1;
    for (int i = first; i < LL; i++) begin
      recv_byte(1'b1, t, bok);
      b[i] = t;
      if (!bok) begin
        ok = 1'b0;
        break;
      end
    end
    hd = {b[0], b[1], b[2], b[LL-2], b[LL-1]};
`ifdef USB_EVLOG_TIMESTAMP_EN
    ts = {b[3], b[4], b[5], b[6], b[7]};
`else
    ts = '0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ev = '0; endpoint = '0; done = 1'b0;
    repeat (3) @(negedge clk48);
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", q); end
    n_tests++; if (dv !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dv); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_tests++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lost: got %0d expected 0", lost_cnt); end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk48);
    n_tests++; if (fifo_empty !== 1'b1 || dv !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got empty=%b dv=%b expected 1/0", fifo_empty, dv);
    end
  endtask

  task automatic test_single();
    logic [39:0] hd, ts;
    bit ok;
    int base;
    base = dv_cnt;
    pulse_ev(8'h04, 4'h3);
    recv_line(0, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(2, 3)) begin
      n_fail++; $display("FAIL single_line: got %h ok=%b expected %h", hd, ok, exp_line(2, 3));
    end
    repeat (20) @(negedge clk48);
    n_tests++; if (dv_cnt - base != LL) begin
      n_fail++; $display("FAIL single_dv_count: got %0d expected %0d", dv_cnt - base, LL);
    end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_simultaneous();
    logic [39:0] hd, ts;
    bit ok;
    pulse_ev(8'b1000_0001, 4'hA);
    recv_line(0, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(0, 10)) begin
      n_fail++; $display("FAIL simul_line0: got %h ok=%b expected %h", hd, ok, exp_line(0, 10));
    end
    recv_line(0, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(7, 10)) begin
      n_fail++; $display("FAIL simul_line1: got %h ok=%b expected %h", hd, ok, exp_line(7, 10));
    end
    n_tests++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL simul_lost: got %0d expected 0", lost_cnt); end
  endtask

  // 17 events: one parked in the serializer, 16 filling the FIFO; then 8 pending + 16 lost.
  task automatic test_backpressure();
    int base;
    base = dv_cnt;
    for (int k = 0; k < 17; k++) pulse_ev(8'(1 << (k % 8)), 4'(k % 16));
    repeat (10) @(negedge clk48);
    n_tests++; if (dv_cnt - base != 1 || q !== 8'h45) begin
      n_fail++; $display("FAIL bp_first_byte: got dv=%0d q=%h expected 1 45", dv_cnt - base, q);
    end
    n_tests++; if (fifo_empty !== 1'b0 || lost_cnt !== 8'd0) begin
      n_fail++; $display("FAIL bp_fill: got empty=%b lost=%0d expected 0 0", fifo_empty, lost_cnt);
    end
    pulse_ev(8'hFF, 4'h5);
    pulse_ev(8'hFF, 4'hF);
    pulse_ev(8'hFF, 4'hF);
    n_tests++; if (lost_cnt !== 8'd16) begin n_fail++; $display("FAIL bp_lost: got %0d expected 16", lost_cnt); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 238; i++) pulse_ev(8'h01, 4'h0);
    n_tests++; if (lost_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", lost_cnt); end
    pulse_ev(8'h01, 4'h0);
    n_tests++; if (lost_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", lost_cnt); end
    for (int i = 0; i < 45; i++) pulse_ev(8'h01, 4'h0);
    n_tests++; if (lost_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", lost_cnt); end
  endtask

  task automatic test_drain();
    logic [39:0] hd, ts;
    bit ok;
    int base;
    base = dv_cnt;
    done = 1'b1;
    @(negedge clk48);
    done = 1'b0;
    recv_line(1, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(0, 0)) begin
      n_fail++; $display("FAIL drain_line0: got %h ok=%b expected %h", hd, ok, exp_line(0, 0));
    end
    for (int k = 1; k < 17; k++) begin
      recv_line(0, hd, ts, ok);
      n_tests++; if (!ok || hd !== exp_line(k % 8, k % 16)) begin
        n_fail++; $display("FAIL drain_line%0d: got %h ok=%b expected %h", k, hd, ok, exp_line(k % 8, k % 16));
      end
    end
    for (int c = 0; c < 8; c++) begin
      recv_line(0, hd, ts, ok);
      n_tests++; if (!ok || hd !== exp_line(c, 5)) begin
        n_fail++; $display("FAIL drain_pending%0d: got %h ok=%b expected %h", c, hd, ok, exp_line(c, 5));
      end
    end
    repeat (20) @(negedge clk48);
    n_tests++; if (dv_cnt - base != 25 * LL - 1) begin
      n_fail++; $display("FAIL drain_dv_count: got %0d expected %0d", dv_cnt - base, 25 * LL - 1);
    end
    n_tests++; if (fifo_empty !== 1'b1 || lost_cnt !== 8'd255) begin
      n_fail++; $display("FAIL drain_end: got empty=%b lost=%0d expected 1 255", fifo_empty, lost_cnt);
    end
  endtask

  task automatic test_midline_reset();
    logic [39:0] hd, ts;
    logic [7:0] b;
    bit ok;
    int snap;
    pulse_ev(8'h10, 4'h2);
    recv_byte(1'b1, b, ok);
    n_tests++; if (!ok || b !== 8'h45) begin n_fail++; $display("FAIL mid_b0: got %h ok=%b expected 45", b, ok); end
    recv_byte(1'b0, b, ok);
    n_tests++; if (!ok || b !== 8'h34) begin n_fail++; $display("FAIL mid_b1: got %h ok=%b expected 34", b, ok); end
    rst_n = 1'b0;
    @(negedge clk48);
    rst_n = 1'b1;
    snap = dv_cnt;
    @(negedge clk48);
    done = 1'b1;
    @(negedge clk48);
    done = 1'b0;
    repeat (30) @(negedge clk48);
    n_tests++; if (dv_cnt != snap || q !== 8'h00) begin
      n_fail++; $display("FAIL mid_quiet: got dv_pulses=%0d q=%h expected 0 00", dv_cnt - snap, q);
    end
    n_tests++; if (fifo_empty !== 1'b1 || lost_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_state: got empty=%b lost=%0d ovf=%b expected 1 0 0", fifo_empty, lost_cnt, overflow);
    end
    pulse_ev(8'h02, 4'h0);
    recv_line(0, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(1, 0)) begin
      n_fail++; $display("FAIL mid_new_line: got %h ok=%b expected %h", hd, ok, exp_line(1, 0));
    end
  endtask

`ifdef USB_EVLOG_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [39:0] hd, ts;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk48);
    rst_n = 1'b1;
    repeat (48 * 'h1234) @(negedge clk48);
    pulse_ev(8'h20, 4'h0);
    recv_line(0, hd, ts, ok);
    n_tests++; if (!ok || hd !== exp_line(5, 0)) begin
      n_fail++; $display("FAIL ts_line: got %h ok=%b expected %h", hd, ok, exp_line(5, 0));
    end
    n_tests++; if (ts !== {8'h20, 8'h31, 8'h32, 8'h33, 8'h34}) begin
      n_fail++; $display("FAIL ts_value: got %h expected 2031323334", ts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_saturation();
    test_drain();
    test_midline_reset();
`ifdef USB_EVLOG_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
